// File: rtl/warp_sequencer_pkg.sv
// Types and width constants shared by the warp sequencer, the register files, the ALU and the LSU.
package warp_sequencer_pkg;

   localparam int unsigned INSTRUCTION_WIDTH                = 32;
   localparam int unsigned INSTRUCTION_MEMORY_ADDRESS_WIDTH = 8;

   typedef enum logic [2:0] {
      WARP_IDLE,
      WARP_FETCH,
      WARP_DECODE,
      WARP_REQUEST,
      WARP_EXECUTE,
      WARP_WAIT,
      WARP_UPDATE,
      WARP_DONE
   } warp_state_t;

   typedef enum logic [1:0] {
      REG_INPUT_ARITHMETIC,
      REG_INPUT_MEMORY,
      REG_INPUT_CONSTANT,
      REG_INPUT_PC_PLUS_1
   } reg_input_mux_t;

endpackage

// File: rtl/warp_sequencer.sv
// Per-warp control FSM: owns pc, the latched instruction and the retire counter, and steps one
// warp through fetch, decode, register request, execute, memory wait and update.
module warp_sequencer
   import warp_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = INSTRUCTION_MEMORY_ADDRESS_WIDTH,
   parameter int unsigned INSTR_WIDTH = INSTRUCTION_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  start_pc,
   output warp_state_t            warp_state,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   fetch_req_valid,
   output logic [ADDR_WIDTH-1:0]  fetch_req_address,
   input  logic                   fetch_resp_valid,
   input  logic [INSTR_WIDTH-1:0] fetch_resp_instruction,
   input  logic                   decoded_mem_read,
   input  logic                   decoded_mem_write,
   input  logic                   decoded_branch,
   input  logic                   decoded_halt,
   input  logic                   branch_taken,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   input  logic                   lsu_done,
   output logic                   done,
   output logic [31:0]            retired_count
);

   warp_state_t            r_state;
   logic [ADDR_WIDTH-1:0]  r_pc;
   logic [ADDR_WIDTH-1:0]  r_target;
   logic [INSTR_WIDTH-1:0] r_instruction;
   logic                   r_take_branch;
   logic                   r_done;
   logic [31:0]            r_retired;

   logic                   w_is_mem;
   logic [ADDR_WIDTH-1:0]  w_next_pc;

   assign w_is_mem  = decoded_mem_read | decoded_mem_write;
   assign w_next_pc = r_take_branch ? r_target : r_pc + ADDR_WIDTH'(1);

   // Reset wins over enable; with enable low every register simply holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= WARP_IDLE;
         r_pc          <= '0;
         r_target      <= '0;
         r_instruction <= '0;
         r_take_branch <= 1'b0;
         r_done        <= 1'b0;
         r_retired     <= '0;
      end else if (enable) begin
         case (r_state)
            WARP_IDLE: begin
               if (start) begin
                  r_pc    <= start_pc;
                  r_state <= WARP_FETCH;
               end
            end
            WARP_FETCH: begin
               if (fetch_resp_valid) begin
                  r_instruction <= fetch_resp_instruction;
                  r_state       <= WARP_DECODE;
               end
            end
            WARP_DECODE: begin
               r_state <= WARP_REQUEST;
            end
            WARP_REQUEST: begin
               r_state <= WARP_EXECUTE;
            end
            WARP_EXECUTE: begin
               r_take_branch <= decoded_branch & branch_taken;
               r_target      <= branch_target;
               r_state       <= w_is_mem ? WARP_WAIT : WARP_UPDATE;
            end
            WARP_WAIT: begin
               if (lsu_done) begin
                  r_state <= WARP_UPDATE;
               end
            end
            WARP_UPDATE: begin
               // pc stays on the retiring instruction for the PC_PLUS_1 writeback this cycle.
               r_retired <= r_retired + 32'd1;
               if (decoded_halt) begin
                  r_done  <= 1'b1;
                  r_state <= WARP_DONE;
               end else begin
                  r_pc    <= w_next_pc;
                  r_state <= WARP_FETCH;
               end
            end
            WARP_DONE: begin
               r_state <= WARP_DONE;
            end
            default: begin
               r_state <= WARP_IDLE;
            end
         endcase
      end
   end

   assign warp_state        = r_state;
   assign pc                = r_pc;
   assign instruction       = r_instruction;
   assign fetch_req_valid   = (r_state == WARP_FETCH) & enable;
   assign fetch_req_address = r_pc;
   assign done              = r_done;
   assign retired_count     = r_retired;

endmodule
